// File: rtl/gf_pkg.sv
// Shared GF(2^m) helpers: elaboration-time log/antilog generators, modular log add, and mode enum.
package gf_pkg;

    typedef enum logic {GF_MULT = 1'b0, GF_MAC = 1'b1} gf_mode_e;

    localparam int unsigned GF_MAX_W = 16;
    typedef logic [GF_MAX_W-1:0] gf_sym_t;
    typedef logic [GF_MAX_W:0]   gf_wide_t;

    function automatic int unsigned gf_lfsr_step(input int unsigned x, input int unsigned w,
                                                 input int unsigned poly);
        int unsigned msk;
        int unsigned nx;
        msk = (32'd1 << w) - 32'd1;
        nx  = (x << 1) & msk;
        if (((x >> (w - 32'd1)) & 32'd1) != 32'd0) begin
            nx = nx ^ (poly & msk);
        end
        return nx;
    endfunction

    function automatic int unsigned gf_gen_antilog(input int unsigned w, input int unsigned poly,
                                                   input int unsigned e);
        int unsigned x;
        x = 32'd1;
        for (int unsigned i = 32'd0; i < e; i++) begin
            x = gf_lfsr_step(x, w, poly);
        end
        return x;
    endfunction

    // Zero has no logarithm; its entry is unused because products with zero are gated.
    function automatic int unsigned gf_gen_log(input int unsigned w, input int unsigned poly,
                                               input int unsigned v);
        int unsigned x;
        int unsigned r;
        x = 32'd1;
        r = 32'd0;
        for (int unsigned i = 32'd0; i < (32'd1 << w) - 32'd1; i++) begin
            if (x == v) begin
                r = i;
            end
            x = gf_lfsr_step(x, w, poly);
        end
        return r;
    endfunction

    function automatic gf_sym_t gf_mod_add(input gf_sym_t a, input gf_sym_t b, input int unsigned w);
        gf_wide_t s;
        gf_wide_t m;
        m = (gf_wide_t'(1) << w) - gf_wide_t'(1);
        s = {1'b0, a} + {1'b0, b};
        if (s >= m) begin
            s = s - m;
        end
        return s[GF_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/gf_mult_lane.sv
// One GF multiplier lane: log lookup and modular sum feed S1; antilog lookup with zero gating follows S1.
module gf_mult_lane
    import gf_pkg::*;
#(
    parameter int unsigned SYMB_WIDTH = 8,
    parameter int unsigned POLY       = 285
) (
    input  logic [SYMB_WIDTH-1:0] a_i,
    input  logic [SYMB_WIDTH-1:0] b_i,
    output logic [SYMB_WIDTH-1:0] log_sum_o,
    output logic                  zero_o,
    input  logic [SYMB_WIDTH-1:0] log_sum_i,
    input  logic                  zero_i,
    output logic [SYMB_WIDTH-1:0] prod_o
);

    localparam int unsigned NSYM = 32'd1 << SYMB_WIDTH;

    logic [SYMB_WIDTH-1:0] log_tbl     [NSYM];
    logic [SYMB_WIDTH-1:0] antilog_tbl [NSYM];

    for (genvar k = 0; k < NSYM; k++) begin : g_tbl
        localparam int unsigned LOG_K = gf_gen_log(SYMB_WIDTH, POLY, k);
        localparam int unsigned ALOG_K = gf_gen_antilog(SYMB_WIDTH, POLY, k);
        assign log_tbl[k]     = SYMB_WIDTH'(LOG_K);
        assign antilog_tbl[k] = SYMB_WIDTH'(ALOG_K);
    end

    assign log_sum_o = SYMB_WIDTH'(gf_mod_add(GF_MAX_W'(log_tbl[a_i]), GF_MAX_W'(log_tbl[b_i]), SYMB_WIDTH));
    assign zero_o    = (a_i == {SYMB_WIDTH{1'b0}}) || (b_i == {SYMB_WIDTH{1'b0}});
    assign prod_o    = zero_i ? {SYMB_WIDTH{1'b0}} : antilog_tbl[log_sum_i];

endmodule

// File: rtl/gf_mac_pipe.sv
// Two-stage multi-lane GF multiplier with valid/ready flow control and a framed XOR-accumulate mode.
module gf_mac_pipe
    import gf_pkg::*;
#(
    parameter int unsigned SYMB_WIDTH = 8,
    parameter int unsigned POLY       = 285,
    parameter int unsigned LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic                        in_sop,
    input  logic                        in_eop,
    input  logic [LANES*SYMB_WIDTH-1:0] in_a,
    input  logic [LANES*SYMB_WIDTH-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*SYMB_WIDTH-1:0] out_p
);

    localparam int unsigned DW = LANES * SYMB_WIDTH;

    logic [DW-1:0]         lsum_s;
    logic [DW-1:0]         lsum_q;
    logic [DW-1:0]         prod_s;
    logic [LANES-1:0]      zero_s;
    logic [LANES-1:0]      zero_q;
    gf_mode_e              mode_q;
    logic                  sop_q;
    logic                  eop_q;
    logic                  valid1_q;
    logic [DW-1:0]         out_p_q;
    logic [DW-1:0]         out_p_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [SYMB_WIDTH-1:0] acc_q;
    logic [SYMB_WIDTH-1:0] acc_d;
    logic [SYMB_WIDTH-1:0] red_s;
    logic [SYMB_WIDTH-1:0] nxt_s;
    logic                  en_s;

    // The whole pipe advances together; a held output freezes both stages.
    assign en_s      = !out_valid_q || out_ready;
    assign in_ready  = en_s;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gf_mult_lane #(.SYMB_WIDTH(SYMB_WIDTH), .POLY(POLY)) u_lane (
            .a_i       (in_a[i*SYMB_WIDTH +: SYMB_WIDTH]),
            .b_i       (in_b[i*SYMB_WIDTH +: SYMB_WIDTH]),
            .log_sum_o (lsum_s[i*SYMB_WIDTH +: SYMB_WIDTH]),
            .zero_o    (zero_s[i]),
            .log_sum_i (lsum_q[i*SYMB_WIDTH +: SYMB_WIDTH]),
            .zero_i    (zero_q[i]),
            .prod_o    (prod_s[i*SYMB_WIDTH +: SYMB_WIDTH])
        );
    end

    // XOR reduction of all lane products for the dot-product path.
    always_comb begin
        red_s = {SYMB_WIDTH{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            red_s = red_s ^ prod_s[i*SYMB_WIDTH +: SYMB_WIDTH];
        end
    end

    // S2 next-state: MULT beats bypass the accumulator so an open frame survives them.
    always_comb begin
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        nxt_s       = (sop_q ? {SYMB_WIDTH{1'b0}} : acc_q) ^ red_s;
        if (en_s) begin
            if (!valid1_q) begin
                out_valid_d = 1'b0;
            end else begin
                case (mode_q)
                    GF_MULT: begin
                        out_p_d     = prod_s;
                        out_valid_d = 1'b1;
                    end
                    GF_MAC: begin
                        if (eop_q) begin
                            out_p_d     = DW'(nxt_s);
                            out_valid_d = 1'b1;
                            acc_d       = {SYMB_WIDTH{1'b0}};
                        end else begin
                            acc_d       = nxt_s;
                            out_valid_d = 1'b0;
                        end
                    end
                    default: begin
                        out_valid_d = 1'b0;
                    end
                endcase
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // S1 registers: log sums, zero flags and beat framing.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            lsum_q   <= {DW{1'b0}};
            zero_q   <= {LANES{1'b0}};
            mode_q   <= GF_MULT;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
        end else if (en_s) begin
            valid1_q <= in_valid;
            lsum_q   <= lsum_s;
            zero_q   <= zero_s;
            mode_q   <= gf_mode_e'(in_mode);
            sop_q    <= in_sop;
            eop_q    <= in_eop;
        end
    end

    // S2 registers: output beat and running accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p_q     <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            acc_q       <= {SYMB_WIDTH{1'b0}};
        end else begin
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_gf_mac_pipe.sv
// Scoreboard bench for gf_mac_pipe: a shift-and-add GF model predicts each output beat.
module tb_gf_mac_pipe;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int DW = W * L;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_p;

    int            checks = 0;
    int            errors = 0;
    int            popped = 0;
    logic [DW-1:0] exp_q[$];
    logic [W-1:0]  macc = '0;
    logic          chk_hold = 1'b0;
    logic [DW-1:0] held_p = '0;

    always #5 clk = ~clk;

    gf_mac_pipe #(.SYMB_WIDTH(W), .POLY(285), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    task automatic model_accept();
        logic [DW-1:0] prods;
        logic [W-1:0]  r;
        logic [W-1:0]  nxt;
        r = 8'h00;
        for (int i = 0; i < L; i++) begin
            prods[i*W +: W] = gf_mul(in_a[i*W +: W], in_b[i*W +: W]);
            r = r ^ prods[i*W +: W];
        end
        if (!in_mode) begin
            exp_q.push_back(prods);
        end else begin
            nxt = (in_sop ? 8'h00 : macc) ^ r;
            if (in_eop) begin
                exp_q.push_back({24'h0, nxt});
                macc = 8'h00;
            end else begin
                macc = nxt;
            end
        end
    endtask

    task automatic tick();
        logic [DW-1:0] e;
        if (chk_hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_p !== held_p) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b p=%h, want valid=1 p=%h", out_valid, out_p, held_p);
            end
        end
        chk_hold = out_valid && !out_ready;
        held_p   = out_p;
        if (out_valid && out_ready) begin
            checks++;
            popped++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got p=%h, want no output", out_p);
            end else begin
                e = exp_q.pop_front();
                if (out_p !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got p=%h, want %h", out_p, e);
                end
            end
        end
        if (in_valid && in_ready) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mode, input logic sop, input logic eop,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_mode  = mode;
        in_sop   = sop;
        in_eop   = eop;
        in_a     = a;
        in_b     = b;
    endtask

    function automatic logic [DW-1:0] rnd_ops();
        logic [DW-1:0] v;
        for (int i = 0; i < L; i++) begin
            v[i*W +: W] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        end
        return v;
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic apply_reset(input int cycles);
        in_valid = 1'b0;
        rst      = 1'b1;
        chk_hold = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid: got out_valid=%b, want 0", out_valid);
            end
        end
        exp_q.delete();
        macc = 8'h00;
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        checks++;
        if (out_valid !== 1'b0 || out_p !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b p=%h ready=%b, want 0/0/1", out_valid, out_p, in_ready);
        end
    endtask

    task automatic test_mult();
        drive(1'b0, 1'b0, 1'b0, 32'h02808002, 32'h8E800202);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mult_latency1: got out_valid=%b, want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_p !== 32'h01131D04) begin
            errors++;
            $display("FAIL mult_basic: got valid=%b p=%h, want 1 01131d04", out_valid, out_p);
        end
        tick();
    endtask

    task automatic test_zero();
        drive(1'b0, 1'b0, 1'b0, 32'h00FF0300, 32'h00000005 | 32'h00010000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h00000003, 32'h00000003);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_p !== 32'h00FF0000) begin
            errors++;
            $display("FAIL mult_zero: got valid=%b p=%h, want 1 00ff0000", out_valid, out_p);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_p !== 32'h00000005) begin
            errors++;
            $display("FAIL mult_3x3: got valid=%b p=%h, want 1 00000005", out_valid, out_p);
        end
        tick();
    endtask

    task automatic test_mac();
        drive(1'b1, 1'b1, 1'b0, 32'h01000302, 32'h07050302);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h00000080, 32'h00000002);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mac_no_partial: got out_valid=%b, want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_p !== 32'h0000001B) begin
            errors++;
            $display("FAIL mac_sum: got valid=%b p=%h, want 1 0000001b", out_valid, out_p);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mac_single: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        int   cyc;
        int   pop0;
        logic acc;
        n    = 0;
        cyc  = 0;
        pop0 = popped;
        drive(1'b0, 1'b0, 1'b0, rnd_ops(), rnd_ops());
        while (n < 8 && cyc < 100) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready_rule: got %b with valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                n++;
                if (n < 8) drive(1'b0, 1'b0, 1'b0, rnd_ops(), rnd_ops());
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bp_accept: got %0d accepted beats, want 8", n);
        end
        drain();
        checks++;
        if (popped - pop0 != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d results, want 8", popped - pop0);
        end
    endtask

    task automatic test_framing();
        drive(1'b1, 1'b1, 1'b1, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b1, 1'b0, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b0, 1'b0, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b1, 1'b0, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b0, 1'b1, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h00000302, 32'h00000302);
        tick();
        drive(1'b0, 1'b1, 1'b1, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b0, 1'b0, rnd_ops(), rnd_ops());
        tick();
        drive(1'b1, 1'b0, 1'b1, rnd_ops(), rnd_ops());
        tick();
        drain();
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 1'b1, 1'b0, 32'h00000302, 32'h00000705);
        tick();
        in_valid = 1'b0;
        tick();
        apply_reset(2);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h00000001, 32'h00000007);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_p !== 32'h00000007) begin
            errors++;
            $display("FAIL reset_frame: got valid=%b p=%h, want 1 00000007", out_valid, out_p);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mult();
        test_zero();
        test_mac();
        drain();
        test_back_to_back();
        test_framing();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
